spi_slave: RTL
==============

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 32: maximum frame length in bits and width of the data ports.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on spi_sclk, spi_mosi and spi_le.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port spi_sclk, input, 1 bit: serial clock from the master, asynchronous to clk.
REQ-006 SHALL have port spi_mosi, input, 1 bit: serial data from the master.
REQ-007 SHALL have port spi_le, input, 1 bit: latch enable; low = frame active, rising edge = latch.
REQ-008 SHALL have port spi_miso, output, 1 bit: serial readback data to the master.
REQ-009 SHALL have port tx_data, input, DATA_W bits: readback word, captured at frame start.
REQ-010 SHALL have port rx_data, output, DATA_W bits: last received word, right-aligned.
REQ-011 SHALL have port rx_bits, output, 6 bits: bit count of the last frame, saturating at DATA_W+1.
REQ-012 SHALL have port rx_valid, output, 1 bit: one-cycle pulse when rx_data/rx_bits update.
REQ-013 SHALL have port frame_err, output, 1 bit: one-cycle pulse, coincident with rx_valid, on overlength frame.

Function
REQ-014 SHALL pass sclk/mosi/le through SYNC_STAGES flops, then edge-detect against a registered copy; only synchronized signals are used.
REQ-015 SHALL use FSM states WAIT_IDLE, IDLE, SHIFT, DONE.
REQ-016 WAIT_IDLE SHALL go to IDLE once synced le=1 (no partial frame is ever accepted).
REQ-017 IDLE SHALL go to SHIFT on synced le falling; at that edge: load tx_data into tx shift reg, clear rx shift reg and count.
REQ-018 In SHIFT, each sclk rising edge SHALL shift synced mosi into rx shift reg LSB (MSB-first protocol) and increment count, saturating at DATA_W+1.
REQ-019 In SHIFT, each sclk falling edge SHALL shift tx shift reg left; spi_miso = tx shift reg MSB, so bit DATA_W-1 is present before the first rising sclk.
REQ-020 SHALL go SHIFT->DONE on synced le rising; if an sclk rising edge is detected in the same cycle, it SHALL be counted first.
REQ-021 DONE SHALL last one cycle then go to IDLE; if count>0: rx_data <= rx shift reg, rx_bits <= count, rx_valid=1; if count=0: outputs unchanged, no pulse.
REQ-022 Frames over DATA_W bits SHALL keep the last DATA_W bits, set rx_bits=DATA_W+1 and pulse frame_err with rx_valid.
REQ-023 Frames under DATA_W bits SHALL leave the upper rx_data bits zero.
REQ-024 rx_valid SHALL assert no later than SYNC_STAGES+2 clk edges after spi_le rising at the pin.
REQ-025 Correct operation requires spi_sclk high and low times each >= (SYNC_STAGES+1) clk periods; faster sclk is unsupported.

Reset
REQ-026 rst_n low SHALL force state WAIT_IDLE, sync flops to 1 for le and 0 for sclk/mosi, shift regs/count/rx_data/rx_bits to 0, and rx_valid/frame_err/spi_miso to 0.
REQ-027 Reset mid-frame SHALL discard the frame; no rx_valid until a complete new le-low/le-high frame.

Configuration
REQ-028 Macro SPI_SLAVE_READBACK_EN defined: spi_miso and the tx shift register operate per REQ-017/REQ-019.
REQ-029 SPI_SLAVE_READBACK_EN undefined: no tx shift register, tx_data ignored, spi_miso constant 0; receive path unchanged.

Structure
REQ-030 Package spi_pkg SHALL hold the FSM state enum, default DATA_W and the counter width constant.
REQ-031 Sub-module spi_sync SHALL implement one SYNC_STAGES synchronizer plus rise/fall detect, instantiated three times.

Verification
REQ-032 le low, 14 bits 10101010101010, le high -> rx_data=0x00002AAA, rx_bits=14, single rx_valid, no frame_err.
REQ-033 32 bits of 0xAAAAAAAA -> rx_data=0xAAAAAAAA, rx_bits=32.
REQ-034 READBACK_EN, tx_data=0x12345678, 32 clocks -> miso sampled on sclk rises reads 0x12345678; macro off -> miso constantly 0.
REQ-035 34 bits 11 followed by 0xCAFEF00D -> rx_data=0xCAFEF00D, rx_bits=33, frame_err and rx_valid pulse together.
REQ-036 rst_n low after 10 bits, released with le low, then 8 bits 0xA5 and le high -> no rx_valid; next full 8-bit 0x3C frame -> rx_data=0x3C.
REQ-037 le low then high with no sclk -> no rx_valid, rx_data unchanged.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: FSM state encoding, default frame
// width and the width of the frame bit counter.
package spi_pkg;

  // Default maximum frame length in bits.
  localparam int DATA_W_DEF = 32;

  // Bit counter width. The counter saturates at DATA_W+1, so this width
  // supports any DATA_W up to 62.
  localparam int CNT_W = 6;

  // Frame controller states.
  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2,
    DONE      = 2'd3
  } spi_state_e;

endpackage : spi_pkg

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input, followed by rise/fall
// detection against a registered copy of the synchronized level.
// RST_VAL sets the reset level of every flop. Setting it to the line's idle
// level means that leaving reset does not produce a false edge.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_chain;
  logic              r_prev;

  // Shift the pin into the synchronizer chain and keep the previous synced level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= {STAGES{RST_VAL}};
      r_prev  <= RST_VAL;
    end else begin
      r_chain <= (r_chain << 1) | STAGES'(i_async);
      r_prev  <= r_chain[STAGES-1];
    end
  end

  assign o_sync = r_chain[STAGES-1];
  assign o_rise =  r_chain[STAGES-1] & ~r_prev;
  assign o_fall = ~r_chain[STAGES-1] &  r_prev;

endmodule : spi_sync

// File: rtl/spi_slave.sv
// SPI slave with a latch-enable (LE) frame strobe.
// - The master shifts data MSB-first on spi_mosi.
// - Each rising edge of spi_sclk captures one bit.
// - The rising edge of spi_le latches the received word into rx_data/rx_bits.
// - All pins are oversampled by clk through synchronizers.
//   sclk high and low times must each be at least SYNC_STAGES+1 clk periods.
// Optional feature: define SPI_SLAVE_READBACK_EN to enable readback.
//   tx_data is captured at frame start and shifted out on spi_miso,
//   and the tx shift register advances on each falling edge of sclk.
//   If the macro is undefined, spi_miso is tied low and tx_data is ignored.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_le,
  output logic              spi_miso,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic [5:0]        rx_bits,
  output logic              rx_valid,
  output logic              frame_err
);

  // The counter stops at this value. A frame that reaches it was longer than DATA_W.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W + 1);

  // Settle timer width. The timer holds WAIT_IDLE until the synchronizers
  // have flushed their reset values.
  localparam int STL_W = $clog2(SYNC_STAGES + 1);

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_mosi_sync, w_mosi_rise, w_mosi_fall;
  logic w_le_sync, w_le_rise, w_le_fall;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(spi_sclk),
    .o_sync (w_sclk_lvl),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(spi_mosi),
    .o_sync (w_mosi_sync),
    .o_rise (w_mosi_rise),
    .o_fall (w_mosi_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_le (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(spi_le),
    .o_sync (w_le_sync),
    .o_rise (w_le_rise),
    .o_fall (w_le_fall)
  );

  spi_state_e         r_state;
  logic [STL_W-1:0]   r_settle;
  logic [DATA_W-1:0]  r_rx_sr;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_rx_data;
  logic [CNT_W-1:0]   r_rx_bits;
  logic               r_rx_valid;
  logic               r_frame_err;
`ifdef SPI_SLAVE_READBACK_EN
  logic [DATA_W-1:0]  r_tx_sr;
`endif

  // Frame controller: sequences the frame and owns the shift registers,
  // the bit counter and the registered outputs.
  //
  // State behaviour:
  // - WAIT_IDLE: entered from reset. After the settle time it waits for LE
  //   to be seen high. A frame already in progress when reset is released
  //   is therefore never accepted.
  // - IDLE: waits for the falling edge of LE.
  // - SHIFT: captures bits on sclk rising edges and advances the readback
  //   register on sclk falling edges. A bit whose sclk rise lands in the
  //   same cycle as the LE rise is still counted.
  // - DONE: publishes the result for one cycle, then returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= WAIT_IDLE;
      r_settle    <= STL_W'(SYNC_STAGES);
      r_rx_sr     <= '0;
      r_cnt       <= '0;
      r_rx_data   <= '0;
      r_rx_bits   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef SPI_SLAVE_READBACK_EN
      r_tx_sr     <= '0;
`endif
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        WAIT_IDLE: begin
          if (r_settle != '0) begin
            r_settle <= r_settle - STL_W'(1);
          end else if (w_le_sync) begin
            r_state <= IDLE;
          end
        end

        IDLE: begin
          if (w_le_fall) begin
            r_state <= SHIFT;
            r_rx_sr <= '0;
            r_cnt   <= '0;
`ifdef SPI_SLAVE_READBACK_EN
            r_tx_sr <= tx_data;
`endif
          end
        end

        SHIFT: begin
          if (w_sclk_rise) begin
            r_rx_sr <= {r_rx_sr[DATA_W-2:0], w_mosi_sync};
            if (r_cnt != CNT_MAX) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
`ifdef SPI_SLAVE_READBACK_EN
          if (w_sclk_fall) begin
            r_tx_sr <= {r_tx_sr[DATA_W-2:0], 1'b0};
          end
`endif
          if (w_le_rise) begin
            r_state <= DONE;
          end
        end

        DONE: begin
          r_state <= IDLE;
          if (r_cnt != '0) begin
            r_rx_data   <= r_rx_sr;
            r_rx_bits   <= r_cnt;
            r_rx_valid  <= 1'b1;
            r_frame_err <= (r_cnt == CNT_MAX);
          end
        end

        default: r_state <= WAIT_IDLE;
      endcase
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_bits   = r_rx_bits;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;

`ifdef SPI_SLAVE_READBACK_EN
  assign spi_miso = r_tx_sr[DATA_W-1];
`else
  assign spi_miso = 1'b0;
`endif

  // These synchronizer outputs have no consumer in every build. They are
  // gathered here on purpose so the omission is visible.
  logic w_unused_sinks;
  assign w_unused_sinks = ^{w_sclk_lvl, w_sclk_fall, w_mosi_rise, w_mosi_fall, tx_data};

endmodule : spi_slave
